// File: rtl/iterative_alu.sv
// Datapath ALU with valid/ready handshake, branch-condition output and a
// one-bit-per-cycle multiply/divide sequencer.
module iterative_alu #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] alu_in_1,
  input  logic [DATA_WIDTH-1:0] alu_in_2,
  input  logic [4:0]            alu_op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic                  alu_bcond
);

  localparam int unsigned W = DATA_WIDTH;

  localparam logic [4:0] OpAdd  = 5'd0;
  localparam logic [4:0] OpSub  = 5'd1;
  localparam logic [4:0] OpAnd  = 5'd2;
  localparam logic [4:0] OpOr   = 5'd3;
  localparam logic [4:0] OpXor  = 5'd4;
  localparam logic [4:0] OpSll  = 5'd5;
  localparam logic [4:0] OpSrl  = 5'd6;
  localparam logic [4:0] OpSra  = 5'd7;
  localparam logic [4:0] OpSlt  = 5'd8;
  localparam logic [4:0] OpSltu = 5'd9;
  localparam logic [4:0] OpJalr = 5'd10;
  localparam logic [4:0] OpBeq  = 5'd11;
  localparam logic [4:0] OpBne  = 5'd12;
  localparam logic [4:0] OpBlt  = 5'd13;
  localparam logic [4:0] OpBge  = 5'd14;
  localparam logic [4:0] OpMul  = 5'd16;
  localparam logic [4:0] OpDiv  = 5'd17;
  localparam logic [4:0] OpDivu = 5'd18;
  localparam logic [4:0] OpRem  = 5'd19;
  localparam logic [4:0] OpRemu = 5'd20;

  localparam logic [SHAMT_WIDTH-1:0] CntOne  = SHAMT_WIDTH'(1);
  localparam logic [SHAMT_WIDTH-1:0] CntLast = SHAMT_WIDTH'(W - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                 state_q;
  logic [SHAMT_WIDTH-1:0] cnt_q;
  logic [4:0]             op_q;
  logic [W-1:0]           a_q, b_q, acc_q, quo_q, rem_q, result_q;
  logic                   neg_quo_q, neg_rem_q, div_zero_q;
  logic                   bcond_q, out_valid_q, in_ready_q;

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign alu_result = result_q;
  assign alu_bcond  = bcond_q;

  // Single-cycle operations, computed straight from the presented operands.
  logic [SHAMT_WIDTH-1:0] shamt;
  logic [W-1:0]           sum, simple_res;
  logic                   simple_bcond;

  always_comb begin
    shamt        = alu_in_2[SHAMT_WIDTH-1:0];
    sum          = alu_in_1 + alu_in_2;
    simple_res   = '0;
    simple_bcond = 1'b0;
    case (alu_op)
      OpAdd:  simple_res = sum;
      OpSub:  simple_res = alu_in_1 - alu_in_2;
      OpAnd:  simple_res = alu_in_1 & alu_in_2;
      OpOr:   simple_res = alu_in_1 | alu_in_2;
      OpXor:  simple_res = alu_in_1 ^ alu_in_2;
      OpSll:  simple_res = alu_in_1 << shamt;
      OpSrl:  simple_res = alu_in_1 >> shamt;
      OpSra:  simple_res = W'($signed(alu_in_1) >>> shamt);
      OpSlt:  simple_res = {{(W-1){1'b0}}, $signed(alu_in_1) < $signed(alu_in_2)};
      OpSltu: simple_res = {{(W-1){1'b0}}, alu_in_1 < alu_in_2};
      OpJalr: simple_res = {sum[W-1:1], 1'b0};
      OpBeq:  simple_bcond = (alu_in_1 == alu_in_2);
      OpBne:  simple_bcond = (alu_in_1 != alu_in_2);
      OpBlt:  simple_bcond = ($signed(alu_in_1) < $signed(alu_in_2));
      OpBge:  simple_bcond = ($signed(alu_in_1) >= $signed(alu_in_2));
      default: ;
    endcase
  end

  // Operand preparation for the sequencer: signed divides run on magnitudes.
  logic         is_iter, signed_div, sign_a, sign_b;
  logic [W-1:0] mag_a, mag_b;

  always_comb begin
    is_iter    = (alu_op >= OpMul) && (alu_op <= OpRemu);
    signed_div = (alu_op == OpDiv) || (alu_op == OpRem);
    sign_a     = signed_div & alu_in_1[W-1];
    sign_b     = signed_div & alu_in_2[W-1];
    mag_a      = sign_a ? -alu_in_1 : alu_in_1;
    mag_b      = sign_b ? -alu_in_2 : alu_in_2;
  end

  // One iteration step; the final step's values feed the result directly.
  logic [W:0]   rem_sh, rem_diff;
  logic         rem_ge;
  logic [W-1:0] rem_nx, quo_nx, acc_nx, quo_fix, rem_fix, iter_res;

  always_comb begin
    rem_sh   = {rem_q, quo_q[W-1]};
    rem_diff = rem_sh - {1'b0, b_q};
    rem_ge   = ~rem_diff[W];
    rem_nx   = rem_ge ? rem_diff[W-1:0] : rem_sh[W-1:0];
    quo_nx   = {quo_q[W-2:0], rem_ge};
    acc_nx   = acc_q + (b_q[0] ? a_q : '0);
    quo_fix  = neg_quo_q ? -quo_nx : quo_nx;
    rem_fix  = neg_rem_q ? -rem_nx : rem_nx;
    case (op_q)
      OpMul:         iter_res = acc_nx;
      OpDiv, OpDivu: iter_res = div_zero_q ? '1 : quo_fix;
      default:       iter_res = div_zero_q ? a_q : rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      div_zero_q  <= 1'b0;
      result_q    <= '0;
      bcond_q     <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            op_q       <= alu_op;
            a_q        <= alu_in_1;
            in_ready_q <= 1'b0;
            if (is_iter) begin
              state_q    <= StBusy;
              cnt_q      <= '0;
              b_q        <= (alu_op == OpMul) ? alu_in_2 : mag_b;
              acc_q      <= '0;
              rem_q      <= '0;
              quo_q      <= mag_a;
              neg_quo_q  <= sign_a ^ sign_b;
              neg_rem_q  <= sign_a;
              div_zero_q <= (alu_in_2 == '0);
            end else begin
              state_q     <= StDone;
              b_q         <= alu_in_2;
              result_q    <= simple_res;
              bcond_q     <= simple_bcond;
              out_valid_q <= 1'b1;
            end
          end
        end
        StBusy: begin
          cnt_q <= cnt_q + CntOne;
          if (op_q == OpMul) begin
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
            acc_q <= acc_nx;
          end else begin
            quo_q <= quo_nx;
            rem_q <= rem_nx;
          end
          if (cnt_q == CntLast) begin
            state_q     <= StDone;
            result_q    <= iter_res;
            bcond_q     <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_alu.sv
// Directed bench for iterative_alu: scoreboarded results, latency and handshake checks,
// plus a 16-bit instance for the width-parametrised multiply.
module tb_iterative_alu;

  localparam int W = 32;
  localparam int H = 16;

  localparam logic [4:0] OpAdd = 5'd0, OpSub = 5'd1, OpSra = 5'd7, OpSltu = 5'd9;
  localparam logic [4:0] OpJalr = 5'd10, OpBeq = 5'd11, OpBne = 5'd12, OpBlt = 5'd13;
  localparam logic [4:0] OpBge = 5'd14, OpMul = 5'd16, OpDiv = 5'd17, OpDivu = 5'd18;
  localparam logic [4:0] OpRem = 5'd19, OpRemu = 5'd20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, in_valid, out_ready, in_ready, out_valid, alu_bcond;
  logic [W-1:0] alu_in_1, alu_in_2, alu_result;
  logic [4:0]   alu_op;

  logic         in_valid_h, out_ready_h, in_ready_h, out_valid_h, alu_bcond_h;
  logic [H-1:0] alu_in_1_h, alu_in_2_h, alu_result_h;
  logic [4:0]   alu_op_h;

  iterative_alu #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_in_1   (alu_in_1),
    .alu_in_2   (alu_in_2),
    .alu_op     (alu_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_result (alu_result),
    .alu_bcond  (alu_bcond)
  );

  iterative_alu #(.DATA_WIDTH(H)) dut_h (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid_h),
    .in_ready   (in_ready_h),
    .alu_in_1   (alu_in_1_h),
    .alu_in_2   (alu_in_2_h),
    .alu_op     (alu_op_h),
    .out_valid  (out_valid_h),
    .out_ready  (out_ready_h),
    .alu_result (alu_result_h),
    .alu_bcond  (alu_bcond_h)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         bc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one op, measure edges until out_valid, optionally stall, then transfer.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] er, input logic eb,
                        input int elat, input int hold, input bit poke);
    int   lat;
    exp_t e;
    @(negedge clk);
    check({tag, "_in_ready"}, W'(in_ready), 1);
    alu_op    = op;
    alu_in_1  = x;
    alu_in_2  = y;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    sb.push_back('{res: er, bc: eb});
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      if (poke) begin
        check({tag, "_busy_in_ready"}, W'(in_ready), 0);
        alu_op   = OpAdd;
        alu_in_1 = 32'h1;
        alu_in_2 = 32'h1;
        in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end
    check({tag, "_latency"}, W'(lat), W'(elat));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, W'(out_valid), 1);
      check({tag, "_hold_result"}, alu_result, sb[0].res);
    end
    out_ready = 1'b1;
    e = sb.pop_front();
    check({tag, "_result"}, alu_result, e.res);
    check({tag, "_bcond"}, W'(alu_bcond), W'(e.bc));
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_post_valid"}, W'(out_valid), 0);
    check({tag, "_post_in_ready"}, W'(in_ready), 1);
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    in_valid = 1'b0;   out_ready = 1'b0;   alu_in_1 = '0;   alu_in_2 = '0;   alu_op = '0;
    in_valid_h = 1'b0; out_ready_h = 1'b0; alu_in_1_h = '0; alu_in_2_h = '0; alu_op_h = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_in_ready", W'(in_ready), 1);
    check("rst_out_valid", W'(out_valid), 0);
    check("rst_result", alu_result, 0);
    check("rst_bcond", W'(alu_bcond), 0);

    run_op("add",   OpAdd,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1, 0, 0);
    run_op("jalr",  OpJalr, 32'h0000_1001, 32'h4,         32'h0000_1004, 1'b0, 1, 0, 0);
    run_op("sub",   OpSub,  32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0, 1, 0, 0);
    run_op("sra",   OpSra,  32'h8000_0000, 32'h24,        32'hF800_0000, 1'b0, 1, 0, 0);
    run_op("sltu",  OpSltu, 32'h1,         32'hFFFF_FFFF, 32'h1,         1'b0, 1, 0, 0);
    run_op("blt",   OpBlt,  32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1, 0, 0);
    run_op("bge",   OpBge,  32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1, 0, 0);
    run_op("beq",   OpBeq,  32'h1234_5678, 32'h1234_5678, 32'h0,         1'b1, 1, 0, 0);
    run_op("bne",   OpBne,  32'h1234_5678, 32'h1234_5678, 32'h0,         1'b0, 1, 0, 0);
    run_op("undef", 5'd15,  32'hDEAD_BEEF, 32'h1,         32'h0,         1'b0, 1, 0, 0);
    run_op("mul",   OpMul,  32'hFFFF_FFFF, 32'h3,         32'hFFFF_FFFD, 1'b0, 33, 0, 1);
    run_op("div",   OpDiv,  32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 1'b0, 33, 0, 0);
    run_op("rem",   OpRem,  32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 1'b0, 33, 0, 0);
    run_op("divu0", OpDivu, 32'h7,         32'h0,         32'hFFFF_FFFF, 1'b0, 33, 0, 0);
    run_op("remu0", OpRemu, 32'h7,         32'h0,         32'h7,         1'b0, 33, 0, 0);
    run_op("div0s", OpDiv,  32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFFF, 1'b0, 33, 0, 0);
    run_op("rem0s", OpRem,  32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 1'b0, 33, 0, 0);
    run_op("divov", OpDiv,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33, 0, 0);
    run_op("remov", OpRem,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b0, 33, 0, 0);
    run_op("divu",  OpDivu, 32'd100,       32'd7,         32'd14,        1'b0, 33, 5, 0);

    // Reset in the middle of a divide must discard it without output.
    @(negedge clk);
    alu_op   = OpDiv;
    alu_in_1 = 32'hFFFF_FFF9;
    alu_in_2 = 32'h2;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_out_valid", W'(out_valid), 0);
    check("midrst_result", alu_result, 0);
    check("midrst_bcond", W'(alu_bcond), 0);
    check("midrst_in_ready", W'(in_ready), 1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("midrst_no_output", W'(out_valid), 0);
    end

    // 16-bit instance: MUL 0xFFFF * 2.
    @(negedge clk);
    check("h_in_ready", W'(in_ready_h), 1);
    alu_op_h   = OpMul;
    alu_in_1_h = 16'hFFFF;
    alu_in_2_h = 16'h0002;
    in_valid_h = 1'b1;
    @(negedge clk);
    in_valid_h = 1'b0;
    lat = 1;
    while (!out_valid_h && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("h_mul_latency", W'(lat), 17);
    check("h_mul_result", W'(alu_result_h), 32'h0000_FFFE);
    check("h_mul_bcond", W'(alu_bcond_h), 0);
    out_ready_h = 1'b1;
    @(negedge clk);
    out_ready_h = 1'b0;
    check("h_post_valid", W'(out_valid_h), 0);
    check("h_post_in_ready", W'(in_ready_h), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iterative_alu.md
Name: iterative_alu

Overview:
- Next-generation datapath ALU for the RISC-V core. Width-parametrised; adds a valid/ready handshake, branch-condition output, signed ops and iterative multiply/divide.
- Sits between ID/EX operand muxes and the EX/MEM latch.
- Simple ops finish one cycle after acceptance. MUL/DIV/REM run a shift-add / restoring-divide sequencer, one bit per cycle.

Parameters:
DATA_WIDTH, 32, operand/result width (>=8, power of two)
SHAMT_WIDTH, $clog2(DATA_WIDTH), shift-amount bits taken from alu_in_2

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operands/op presented
in_ready  output  1  block can accept an op
alu_in_1  input  DATA_WIDTH  operand A (rs1/PC)
alu_in_2  input  DATA_WIDTH  operand B (rs2/imm)
alu_op  input  5  operation select (encoding below)
out_valid  output  1  result/bcond valid
out_ready  input  1  consumer takes result
alu_result  output  DATA_WIDTH  result
alu_bcond  output  1  branch taken flag

Behaviour:
- Op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
  - 10 JALR: (A+B) & ~1.
  - 11 BEQ, 12 BNE, 13 BLT (signed), 14 BGE (signed).
  - 16 MUL: low DATA_WIDTH bits of A*B.
  - 17 DIV, 18 DIVU, 19 REM, 20 REMU.
  - Any other code: result 0, bcond 0, simple-op latency.
- Shifts use alu_in_2[SHAMT_WIDTH-1:0] only. SRA sign-fills.
- Branch ops: alu_result=0, alu_bcond=compare outcome. All other ops: alu_bcond=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch A, B and op. Simple op: compute, go to DONE. MUL/DIV class: go to BUSY, counter=0.
  - BUSY: one iteration per cycle, counter++. When counter reaches DATA_WIDTH-1, load the result register and go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- in_ready is 0 in BUSY and DONE. Operands and op are ignored outside IDLE.
- Latency, where acceptance is the rising edge N with in_valid & in_ready:
  - Simple op: out_valid high from edge N+1.
  - MUL/DIV class: out_valid high from edge N+1+DATA_WIDTH (fixed, data-independent).
- Handshake:
  - alu_result and alu_bcond stay stable while out_valid=1 and out_ready=0.
  - A transfer occurs on an edge with out_valid & out_ready.
  - in_ready rises the cycle after the transfer, so there is no same-cycle back-to-back.
- Signed divide: operate on magnitudes; quotient sign = sign(A)^sign(B), remainder sign = sign(A).
- Divide by zero (fixed latency still applies):
  - DIV/DIVU quotient = all ones.
  - REM/REMU result = A.
- Signed overflow (A = most-negative, B = -1): DIV result = A, REM result = 0.
- MUL is sign-agnostic; only the low half is kept, overflow is discarded.
- Adds and subtracts wrap modulo 2^DATA_WIDTH.
- Reset, including mid-BUSY or DONE:
  - state <- IDLE, counter <- 0.
  - alu_result <- 0, alu_bcond <- 0, out_valid <- 0.
  - in_ready is 1 from the first cycle after reset.
  - Any in-flight op is discarded with no output.

Test Plan:
- Reset then ADD 0x7FFFFFFF+1 with out_ready=1 -> out_valid at N+1, result 0x80000000, bcond 0. Then JALR 0x1001+0x4 -> 0x00001004.
- SRA 0x80000000 by alu_in_2=0x24 (uses 4) -> 0xF8000000. BLT -1 vs 1 -> bcond 1, result 0. BGE same operands -> bcond 0.
- MUL 0xFFFFFFFF*0x3 -> out_valid exactly 33 edges after acceptance, result 0xFFFFFFFD. in_ready 0 throughout, and a second in_valid during BUSY is ignored.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7; DIV 0x80000000/-1 -> 0x80000000; REM of the same -> 0.
- DIVU 100/7 with out_ready held 0 for 5 cycles -> result 14 stable, out_valid held. The transfer edge drops out_valid and in_ready returns to 1 next cycle.
- Assert reset 10 cycles into a DIV -> next cycle IDLE, out_valid 0, result 0, no spurious output. DATA_WIDTH=16 rerun: MUL 0xFFFF*2 -> 0xFFFE after 17 edges.
